// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: FSM state codes, operation codes and
// the select/carry-in values driven to the external adder/subtractor.
package alu_seq_pkg;

  // FSM state codes, also shown on the LED display
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GOT_A = 3'd1;
  localparam logic [2:0] ST_GOT_B = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_SHOW  = 3'd4;

  // Operation codes as presented on OP
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_ADC     = 2'b01;
  localparam logic [1:0] OP_SUB     = 2'b10;
  localparam logic [1:0] OP_ADD_ALT = 2'b11;

  // Datapath mux selects
  localparam logic [1:0] SEL_IDLE = 2'b00;
  localparam logic [1:0] SEL_ADD  = 2'b01;
  localparam logic [1:0] SEL_SUB  = 2'b10;

  // Datapath select for a latched operation
  function automatic logic [1:0] op_sel(input logic [1:0] op);
    logic [1:0] sel;
    case (op)
      OP_ADD, OP_ADC, OP_ADD_ALT: sel = SEL_ADD;
      OP_SUB:                     sel = SEL_SUB;
      default:                    sel = SEL_IDLE;
    endcase
    return sel;
  endfunction

  // Carry-in for a latched operation; only the add-with-carry form sets it
  function automatic logic op_cin(input logic [1:0] op);
    return (op == OP_ADC);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Sequencer for a shared external 4-bit adder/subtractor. Collects two operand
// nibbles from switches, fires one datapath cycle, and registers the result.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] din_i,
  input  logic       load_i,
  input  logic [1:0] op_i,
  input  logic       chain_i,
  input  logic       clr_i,
  input  logic [3:0] dp_s_i,
  input  logic       dp_cout_i,
  output logic [3:0] dp_a_o,
  output logic [3:0] dp_b_o,
  output logic       dp_cin_o,
  output logic [1:0] dp_sel_o,
  output logic [3:0] result_o,
  output logic       cout_reg_o,
  output logic       done_o,
  output logic       busy_o,
  output logic [2:0] state_o,
  output logic [7:0] ops_cnt_o
);

  logic [2:0] state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [1:0] op_q, op_d;
  logic [3:0] result_q, result_d;
  logic       cout_q, cout_d;
  logic       done_q, done_d;
  logic [7:0] ops_cnt_q, ops_cnt_d;

  // Next-state, operand capture and result sampling
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    result_d  = result_q;
    cout_d    = cout_q;
    done_d    = 1'b0;
    ops_cnt_d = ops_cnt_q;

    if (clr_i) begin
      // Abort wins over everything, including an EXEC in flight
      state_d = ST_IDLE;
      a_d     = '0;
      b_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_i) begin
            a_d     = din_i;
            state_d = ST_GOT_A;
          end
        end
        ST_GOT_A: begin
          if (load_i) begin
            b_d     = din_i;
            op_d    = op_i;
            state_d = ST_GOT_B;
          end
        end
        ST_GOT_B: begin
          state_d = ST_EXEC;
        end
        ST_EXEC: begin
          result_d  = dp_s_i;
          cout_d    = dp_cout_i;
          ops_cnt_d = ops_cnt_q + 8'd1;
          done_d    = 1'b1;
          state_d   = ST_SHOW;
        end
        ST_SHOW: begin
          if (load_i) begin
            if (chain_i) begin
              // Previous result becomes A; this nibble is B, skip GOT_A
              a_d     = result_q;
              b_d     = din_i;
              op_d    = op_i;
              state_d = ST_GOT_B;
            end else begin
              a_d     = din_i;
              state_d = ST_GOT_A;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_ADD;
      result_q  <= '0;
      cout_q    <= 1'b0;
      done_q    <= 1'b0;
      ops_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      result_q  <= result_d;
      cout_q    <= cout_d;
      done_q    <= done_d;
      ops_cnt_q <= ops_cnt_d;
    end
  end

  // Datapath controls are only live during EXEC
  always_comb begin
    dp_sel_o = SEL_IDLE;
    dp_cin_o = 1'b0;
    if (state_q == ST_EXEC) begin
      dp_sel_o = op_sel(op_q);
      dp_cin_o = op_cin(op_q);
    end
  end

  // Status outputs
  always_comb begin
    busy_o = (state_q == ST_GOT_A) || (state_q == ST_GOT_B) || (state_q == ST_EXEC);
  end

  assign dp_a_o     = a_q;
  assign dp_b_o     = b_q;
  assign result_o   = result_q;
  assign cout_reg_o = cout_q;
  assign done_o     = done_q;
  assign state_o    = state_q;
  assign ops_cnt_o  = ops_cnt_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: reference adder/subtractor model, table-driven
// operations, directed chain/abort/reset sequences and an OPS_CNT wrap run.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] din_i;
  logic       load_i;
  logic [1:0] op_i;
  logic       chain_i;
  logic       clr_i;
  logic [3:0] dp_s_i;
  logic       dp_cout_i;
  logic [3:0] dp_a_o;
  logic [3:0] dp_b_o;
  logic       dp_cin_o;
  logic [1:0] dp_sel_o;
  logic [3:0] result_o;
  logic       cout_reg_o;
  logic       done_o;
  logic       busy_o;
  logic [2:0] state_o;
  logic [7:0] ops_cnt_o;

  alu_sequencer u_dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .din_i      (din_i),
    .load_i     (load_i),
    .op_i       (op_i),
    .chain_i    (chain_i),
    .clr_i      (clr_i),
    .dp_s_i     (dp_s_i),
    .dp_cout_i  (dp_cout_i),
    .dp_a_o     (dp_a_o),
    .dp_b_o     (dp_b_o),
    .dp_cin_o   (dp_cin_o),
    .dp_sel_o   (dp_sel_o),
    .result_o   (result_o),
    .cout_reg_o (cout_reg_o),
    .done_o     (done_o),
    .busy_o     (busy_o),
    .state_o    (state_o),
    .ops_cnt_o  (ops_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference external datapath
  logic [4:0] dp_full;
  always_comb begin
    dp_full = '0;
    case (dp_sel_o)
      2'b01:   dp_full = {1'b0, dp_a_o} + {1'b0, dp_b_o} + {4'b0, dp_cin_o};
      2'b10:   dp_full = {1'b0, dp_a_o} - {1'b0, dp_b_o};
      default: dp_full = '0;
    endcase
  end
  assign dp_s_i    = dp_full[3:0];
  assign dp_cout_i = dp_full[4];

  int tests_run = 0;
  int tests_failed = 0;
  int exp_ops = 0;
  logic [4:0] sb_q[$];

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected {cout, result} for an operation, independent of the DUT
  function automatic logic [4:0] ref_calc(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] op);
    logic [4:0] r;
    case (op)
      2'b01:   r = {1'b0, a} + {1'b0, b} + 5'd1;
      2'b10:   r = {1'b0, a} - {1'b0, b};
      default: r = {1'b0, a} + {1'b0, b};
    endcase
    return r;
  endfunction

  // Scoreboard: every DONE pops one expected result
  always @(negedge clk_i) begin
    if (!rst_i && done_o) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        logic [4:0] e;
        e = sb_q.pop_front();
        chk("sb_result", int'(result_o), int'(e[3:0]));
        chk("sb_cout", int'(cout_reg_o), int'(e[4]));
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_load(input logic [3:0] d, input logic [1:0] op, input logic ch);
    din_i = d; op_i = op; chain_i = ch; load_i = 1'b1;
    step();
    load_i = 1'b0; chain_i = 1'b0;
  endtask

  // Checks the three cycles after B is captured (GOT_B, EXEC, SHOW/DONE)
  task automatic finish_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                           input logic [4:0] exp);
    chk("gotb_state", int'(state_o), int'(ST_GOT_B));
    chk("gotb_busy", int'(busy_o), 1);
    chk("gotb_sel_idle", int'(dp_sel_o), 0);
    chk("gotb_done", int'(done_o), 0);
    step();
    chk("exec_state", int'(state_o), int'(ST_EXEC));
    chk("exec_sel", int'(dp_sel_o), (op == 2'b10) ? 2 : 1);
    chk("exec_cin", int'(dp_cin_o), (op == 2'b01) ? 1 : 0);
    chk("exec_a", int'(dp_a_o), int'(a));
    chk("exec_b", int'(dp_b_o), int'(b));
    step();
    exp_ops = (exp_ops + 1) % 256;
    chk("show_state", int'(state_o), int'(ST_SHOW));
    chk("show_done", int'(done_o), 1);
    chk("show_busy", int'(busy_o), 0);
    chk("show_result", int'(result_o), int'(exp[3:0]));
    chk("show_cout", int'(cout_reg_o), int'(exp[4]));
    chk("ops_cnt", int'(ops_cnt_o), exp_ops);
    step();
    chk("done_once", int'(done_o), 0);
    chk("result_hold", int'(result_o), int'(exp[3:0]));
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                        input logic [4:0] exp);
    pulse_load(a, 2'b00, 1'b0);
    chk("gota_state", int'(state_o), int'(ST_GOT_A));
    pulse_load(b, op, 1'b0);
    sb_q.push_back(exp);
    finish_op(a, b, op, exp);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] res;
    logic       cout;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{a: 4'd5,  b: 4'd3,  op: 2'b00, res: 4'd8,  cout: 1'b0};
    vecs[1] = '{a: 4'd9,  b: 4'd8,  op: 2'b00, res: 4'd1,  cout: 1'b1};
    vecs[2] = '{a: 4'd7,  b: 4'd8,  op: 2'b01, res: 4'd0,  cout: 1'b1};
    vecs[3] = '{a: 4'd7,  b: 4'd2,  op: 2'b10, res: 4'd5,  cout: 1'b0};
    vecs[4] = '{a: 4'd15, b: 4'd1,  op: 2'b11, res: 4'd0,  cout: 1'b1};
    vecs[5] = '{a: 4'd2,  b: 4'd5,  op: 2'b10, res: 4'd13, cout: 1'b1};
    vecs[6] = '{a: 4'd0,  b: 4'd0,  op: 2'b01, res: 4'd1,  cout: 1'b0};
    vecs[7] = '{a: 4'd9,  b: 4'd8,  op: 2'b00, res: 4'd1,  cout: 1'b1};

    rst_i = 1'b1; din_i = '0; load_i = 1'b0; op_i = '0; chain_i = 1'b0; clr_i = 1'b0;
    step();
    step();
    chk("rst_state", int'(state_o), int'(ST_IDLE));
    chk("rst_result", int'(result_o), 0);
    chk("rst_cout", int'(cout_reg_o), 0);
    chk("rst_ops", int'(ops_cnt_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_sel", int'(dp_sel_o), 0);
    chk("rst_cin", int'(dp_cin_o), 0);
    chk("rst_dp_a", int'(dp_a_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    step();

    // Table-driven operations; vector 7 leaves RESULT=1 for the chain case
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, {vecs[i].cout, vecs[i].res});
    end

    // Chain: RESULT(1) becomes A, DIN=4 is B, straight to GOT_B
    pulse_load(4'd4, 2'b00, 1'b1);
    sb_q.push_back(5'd5);
    finish_op(4'd1, 4'd4, 2'b00, 5'd5);

    // LOAD in GOT_B and EXEC is ignored
    pulse_load(4'd3, 2'b00, 1'b0);
    pulse_load(4'd4, 2'b00, 1'b0);
    sb_q.push_back(5'd7);
    chk("ign_gotb_state", int'(state_o), int'(ST_GOT_B));
    pulse_load(4'd9, 2'b10, 1'b0);
    chk("ign_exec_state", int'(state_o), int'(ST_EXEC));
    chk("ign_exec_sel", int'(dp_sel_o), 1);
    chk("ign_exec_b", int'(dp_b_o), 4);
    pulse_load(4'd12, 2'b10, 1'b0);
    exp_ops++;
    chk("ign_show_state", int'(state_o), int'(ST_SHOW));
    chk("ign_show_a", int'(dp_a_o), 3);
    chk("ign_show_b", int'(dp_b_o), 4);
    chk("ign_result", int'(result_o), 7);

    // Abort: CLR together with LOAD in GOT_A
    pulse_load(4'd6, 2'b00, 1'b0);
    chk("abort_gota", int'(state_o), int'(ST_GOT_A));
    clr_i = 1'b1;
    pulse_load(4'd2, 2'b00, 1'b0);
    clr_i = 1'b0;
    chk("abort_state", int'(state_o), int'(ST_IDLE));
    chk("abort_a", int'(dp_a_o), 0);
    chk("abort_b", int'(dp_b_o), 0);
    chk("abort_ops", int'(ops_cnt_o), exp_ops);
    chk("abort_result", int'(result_o), 7);
    step();
    chk("abort_stay_idle", int'(state_o), int'(ST_IDLE));

    // Reset asserted mid-EXEC discards the operation
    pulse_load(4'd1, 2'b00, 1'b0);
    pulse_load(4'd2, 2'b00, 1'b0);
    step();
    chk("rexec_state", int'(state_o), int'(ST_EXEC));
    rst_i = 1'b1;
    #2;
    sb_q.delete();
    exp_ops = 0;
    chk("rexec_state0", int'(state_o), int'(ST_IDLE));
    chk("rexec_result", int'(result_o), 0);
    chk("rexec_cout", int'(cout_reg_o), 0);
    chk("rexec_ops", int'(ops_cnt_o), 0);
    chk("rexec_sel", int'(dp_sel_o), 0);
    chk("rexec_busy", int'(busy_o), 0);
    chk("rexec_a", int'(dp_a_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    step();
    step();
    chk("rexec_no_done", int'(done_o), 0);
    chk("rexec_ops_after", int'(ops_cnt_o), 0);

    // Wrap: 256 operations bring OPS_CNT back to 0
    for (int i = 0; i < 256; i++) begin
      logic [3:0] a, b;
      logic [1:0] op;
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      op = 2'($urandom_range(0, 3));
      run_op(a, b, op, ref_calc(a, b, op));
      if (i == 254) chk("ops_255", int'(ops_cnt_o), 255);
    end
    chk("ops_wrap", int'(ops_cnt_o), 0);

    step();
    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
